// File: rtl/clint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clint_pkg
// Brief    : CLINT register offsets, address decode and byte-merge helpers.
// Revision : 1.0 - initial release
// ============================================================================
package clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    typedef enum logic [1:0] {
        KIND_NONE     = 2'd0,
        KIND_MSIP     = 2'd1,
        KIND_MTIMECMP = 2'd2,
        KIND_MTIME    = 2'd3
    } reg_kind_t;

    typedef struct packed {
        reg_kind_t   kind;
        logic [13:0] hart;
        logic        hi;
    } reg_dec_t;

    // Takes the word index (byte offset bits [15:2]); out-of-range harts decode to KIND_NONE.
    function automatic reg_dec_t decode_addr(input logic [13:0] word_idx, input int n_harts);
        logic [15:0] word;
        logic [15:0] msip_off;
        logic [15:0] cmp_off;
        reg_dec_t    dec;
        word     = {word_idx, 2'b00};
        msip_off = word - MSIP_BASE;
        cmp_off  = word - MTIMECMP_BASE;
        dec.kind = KIND_NONE;
        dec.hart = '0;
        dec.hi   = 1'b0;
        if (word == MTIME_LO || word == MTIME_HI) begin
            dec.kind = KIND_MTIME;
            dec.hi   = word[2];
        end else if (word < MTIMECMP_BASE) begin
            dec.kind = KIND_MSIP;
            dec.hart = msip_off[15:2];
        end else begin
            dec.kind = KIND_MTIMECMP;
            dec.hart = {1'b0, cmp_off[15:3]};
            dec.hi   = cmp_off[2];
        end
        if (dec.kind != KIND_MTIME && {18'd0, dec.hart} >= 32'(n_harts)) begin
            dec.kind = KIND_NONE;
        end
        return dec;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clint_smp_if.sv
`default_nettype none
// ============================================================================
// Module   : clint_smp_if
// Brief    : Word-wide CLINT register port (interconnect side is master).
// Revision : 1.0 - initial release
// ============================================================================
interface clint_smp_if;

    logic        w_re;
    logic        w_we;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    modport master (
        output w_re, w_we, w_addr, w_wdata, w_be,
        input  r_rdata, r_rvalid
    );

    modport slave (
        input  w_re, w_we, w_addr, w_wdata, w_be,
        output r_rdata, r_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/clint_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : clint_prescaler
// Brief    : Counts 0..TICK_DIV-1 and flags the wrap cycle as the mtime tick.
// Revision : 1.0 - initial release
// ============================================================================
module clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  wire  CLK,
    input  wire  RST,
    input  wire  i_clr,
    output logic o_tick
);

    localparam logic [15:0] c_LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;

    assign o_tick = (r_cnt == c_LAST);

    always_ff @(posedge CLK) begin
        if (RST || i_clr) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clint_smp.sv
`default_nettype none
// ============================================================================
// Module   : clint_smp
// Brief    : Core-local interruptor: shared mtime, per-hart mtimecmp and msip.
// Build    : define CLINT_CMP_ATOMIC_EN for shadowed mtimecmp low-word writes
// Revision : 1.0 - initial release
// ============================================================================
module clint_smp
    import clint_pkg::*;
#(
    parameter int N_HARTS  = 2,
    parameter int TICK_DIV = 1
) (
    input  wire                 CLK,
    input  wire                 RST,
    clint_smp_if.slave          bus,
    output logic [63:0]         w_mtime,
    output logic [N_HARTS-1:0]  r_mtip,
    output logic [N_HARTS-1:0]  w_msip
);

    reg_dec_t           w_dec;
    logic               w_mtime_wr;
    logic               w_tick;
    logic               w_unused;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_cmp_lo [N_HARTS];
    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp [N_HARTS];
    logic [N_HARTS-1:0] r_msip;
`ifdef CLINT_CMP_ATOMIC_EN
    logic [31:0]        r_shadow [N_HARTS];
    logic [N_HARTS-1:0] r_pending;
`endif

    assign w_dec      = decode_addr(bus.w_addr[15:2], N_HARTS);
    assign w_mtime_wr = bus.w_we && (w_dec.kind == KIND_MTIME);
    assign w_unused   = ^bus.w_addr[1:0];
    assign w_mtime    = r_mtime;
    assign w_msip     = r_msip;

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK    (CLK),
        .RST    (RST),
        .i_clr  (w_mtime_wr),
        .o_tick (w_tick)
    );

    // Software-visible low word: a pending shadow hides the committed value.
    for (genvar g = 0; g < N_HARTS; g++) begin : g_lo_view
`ifdef CLINT_CMP_ATOMIC_EN
        assign w_cmp_lo[g] = r_pending[g] ? r_shadow[g] : r_mtimecmp[g][31:0];
`else
        assign w_cmp_lo[g] = r_mtimecmp[g][31:0];
`endif
    end

    always_comb begin
        w_rd_word = '0;
        case (w_dec.kind)
            KIND_MSIP: begin
                for (int i = 0; i < N_HARTS; i++) begin
                    if (w_dec.hart == 14'(i)) w_rd_word = {31'd0, r_msip[i]};
                end
            end
            KIND_MTIMECMP: begin
                for (int i = 0; i < N_HARTS; i++) begin
                    if (w_dec.hart == 14'(i)) begin
                        w_rd_word = w_dec.hi ? r_mtimecmp[i][63:32] : w_cmp_lo[i];
                    end
                end
            end
            KIND_MTIME: w_rd_word = w_dec.hi ? r_mtime[63:32] : r_mtime[31:0];
            default:    w_rd_word = '0;
        endcase
    end

    // A software write to mtime takes priority over that cycle's tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mtime <= '0;
        end else if (w_mtime_wr) begin
            if (w_dec.hi) r_mtime[63:32] <= merge_be(r_mtime[63:32], bus.w_wdata, bus.w_be);
            else          r_mtime[31:0]  <= merge_be(r_mtime[31:0], bus.w_wdata, bus.w_be);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_msip <= '0;
            r_mtip <= '0;
            for (int i = 0; i < N_HARTS; i++) begin
                r_mtimecmp[i] <= '1;
`ifdef CLINT_CMP_ATOMIC_EN
                r_shadow[i]   <= '0;
`endif
            end
`ifdef CLINT_CMP_ATOMIC_EN
            r_pending <= '0;
`endif
        end else begin
            for (int i = 0; i < N_HARTS; i++) begin
                r_mtip[i] <= (r_mtime >= r_mtimecmp[i]);
                if (bus.w_we && w_dec.hart == 14'(i)) begin
                    if (w_dec.kind == KIND_MSIP && bus.w_be[0]) begin
                        r_msip[i] <= bus.w_wdata[0];
                    end
                    if (w_dec.kind == KIND_MTIMECMP) begin
`ifdef CLINT_CMP_ATOMIC_EN
                        if (w_dec.hi) begin
                            r_mtimecmp[i] <= {merge_be(r_mtimecmp[i][63:32], bus.w_wdata, bus.w_be),
                                              w_cmp_lo[i]};
                            r_pending[i]  <= 1'b0;
                        end else begin
                            r_shadow[i]   <= merge_be(w_cmp_lo[i], bus.w_wdata, bus.w_be);
                            r_pending[i]  <= 1'b1;
                        end
`else
                        if (w_dec.hi) begin
                            r_mtimecmp[i][63:32] <= merge_be(r_mtimecmp[i][63:32], bus.w_wdata, bus.w_be);
                        end else begin
                            r_mtimecmp[i][31:0]  <= merge_be(w_cmp_lo[i], bus.w_wdata, bus.w_be);
                        end
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.r_rvalid <= 1'b0;
            bus.r_rdata  <= '0;
        end else begin
            bus.r_rvalid <= bus.w_re;
            if (bus.w_re) bus.r_rdata <= w_rd_word;
        end
    end

endmodule
`default_nettype wire

// File: doc/clint_smp.md
# clint_smp

Core-local interruptor for the SMP cluster; it sits directly upstream of the hart cluster. It holds the shared 64-bit `mtime` counter, one `mtimecmp` register per hart and one `msip` bit per hart. It drives the per-hart timer-interrupt and software-interrupt vectors plus `w_mtime` into the cluster. The word-wide register port is driven by the system interconnect when a cluster data access decodes to the CLINT window.

## Interface
- `N_HARTS`, 2: number of harts; valid range 1–16.
- `TICK_DIV`, 1: `CLK` cycles per `mtime` increment; valid range 1–65535.
- `CLK` input 1: sole clock; rising edge.
- `RST` input 1: reset; synchronous, active-high.
- `w_re` input 1: read strobe, one cycle.
- `w_we` input 1: write strobe, one cycle.
- `w_addr` input 16: byte offset within the CLINT window; bits [1:0] are ignored.
- `w_wdata` input 32: write data.
- `w_be` input 4: byte enables for writes.
- `r_rdata` output 32: read data.
- `r_rvalid` output 1: read data valid.
- `w_mtime` output 64: current `mtime`.
- `r_mtip` output N_HARTS: per-hart machine timer-interrupt pending.
- `w_msip` output N_HARTS: per-hart machine software-interrupt pending.

## Operation
- Address map, in the standard CLINT layout:
  - `msip[i]` at 0x0000+4i; only bit 0 is implemented and all other bits read 0.
  - `mtimecmp[i]` low word at 0x4000+8i, high word at 0x4004+8i.
  - `mtime` low word at 0xBFF8, high word at 0xBFFC.
- Unmapped offsets, including a hart index ≥ N_HARTS: reads return 0 with `r_rvalid` still asserted; writes are ignored.
- Writes merge `w_wdata` into the addressed word byte-by-byte under `w_be`. For `msip`, only `w_be[0]` matters.
- Prescaler:
  - The counter counts 0..TICK_DIV-1.
  - On the wrap cycle, `mtime` increments by 1 modulo 2^64.
  - With TICK_DIV=1, `mtime` increments every cycle.
- A software write to either `mtime` word loads that word and resets the prescaler to 0. That cycle's increment is suppressed: the write wins.
- `r_mtip[i]` is registered from (`mtime` ≥ `mtimecmp[i]`), unsigned 64-bit compare of the current register values.
- `w_re` and `w_we` asserted together: the write is performed, the read returns the pre-write value.
- Reset values:
  - `mtime` = 0, prescaler = 0.
  - Every `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF.
  - `msip` = 0, `r_mtip` = 0.
  - `r_rdata` = 0, `r_rvalid` = 0.
  - Any shadow register and its pending flag are cleared.
- `RST` mid-operation discards any in-flight read: `r_rvalid` is 0 the cycle after `RST`.

## Timing
- Read: `w_re` in cycle T gives `r_rdata`/`r_rvalid` in cycle T+1, valid for one cycle. Back-to-back reads run at one per cycle.
- Write: `w_we` in cycle T makes the register hold the new value in T+1.
- `w_msip` is a direct register output, asserted in T+1 after a write of 1.
- `r_mtip` updates one cycle after the compare condition changes:
  - `mtimecmp` write in T gives `r_mtip` in T+2.
  - `mtime` crossing `mtimecmp` in T gives `r_mtip` in T+1.
- `mtime` wrap from all-ones to 0: `r_mtip` deasserts for any hart whose `mtimecmp` is nonzero.

## Configuration
- `CLINT_CMP_ATOMIC_EN` defined:
  - A write to a `mtimecmp[i]` low word goes to a per-hart 32-bit shadow register and sets a pending flag.
  - A write to the high word of the same hart commits {new high, shadow} in one cycle and clears the flag.
  - Reads of the low word return the shadow while the flag is set.
  - This prevents a spurious `r_mtip` from the half-updated value.
- `CLINT_CMP_ATOMIC_EN` undefined: each half is written directly. No shadow registers exist.

## Structure
- Package `clint_pkg` holds:
  - the offset constants `MSIP_BASE`, `MTIMECMP_BASE`, `MTIME_LO`, `MTIME_HI`;
  - a function decoding `w_addr` to {kind, hart index, hi/lo}.
- Sub-module `clint_prescaler` contains the TICK_DIV counter, with a synchronous clear input and a tick output. The top level instantiates it once.

## Test plan
- **Reset defaults, prescaler period:** TICK_DIV=4, `RST` pulse, then 12 idle cycles -> `w_mtime`=3, `r_mtip`=0, `w_msip`=0, and a read of 0x4000 returns 0xFFFF_FFFF.
- **Timer interrupt latency:** `mtimecmp[1]`=10, then wait -> `r_mtip[1]` rises exactly one cycle after `w_mtime` reaches 10; `r_mtip[0]` stays 0. Writing `mtimecmp[1]`=0xFFFF_FFFF_FFFF_FFFF then clears `r_mtip[1]` two cycles after the write.
- **Software interrupt:** write 0x1 to 0x0004 -> `w_msip`=2'b10 the next cycle. Write 0xFFFF_FFFE to 0x0004 -> `w_msip`=0. Read 0x0004 -> 0.
- **Write vs tick:** write `mtime` low = 0x100 in a tick cycle -> `w_mtime`=0x100 the next cycle, not 0x101. The next increment comes TICK_DIV cycles later.
- **Byte enables and unmapped access:** `w_be`=4'b0010 with `w_wdata`=0xAABBCCDD to 0xBFF8 -> only bits [15:8] change to 0xCC. Read 0x4010 with N_HARTS=2 -> 0, `r_rvalid`=1.
- **Atomic compare (with `CLINT_CMP_ATOMIC_EN`):** `mtime`=5; write `mtimecmp[0]` low = 0 -> `r_mtip[0]` stays 0. Then write high = 0 -> `r_mtip[0]`=1 two cycles later. Without the macro, `r_mtip[0]` stays 0 after the low write only because the high word is still all-ones; the direct write is confirmed by reading back 0.
